ram_dump_reader: RTL and testbench

- Hardware reader for the MPU's byte-wide RAM; the read-side counterpart of the file-driven RAM preload writer.
- On Start, reads Count consecutive bytes from BaseAddr through the RAM's Enable/ReadWrite/MOC handshake.
- Emits each byte on a valid/ready stream to a UART or bench monitor for post-run memory dumps and self-checks.
- Sits beside the datapath MAR/MDR path and is muxed onto the RAM port while Busy=1.

---
 rtl/sparc_mem_pkg.sv | 25 ++
 rtl/mem_req_timer.sv | 41 ++++
 rtl/ram_dump_reader.sv | 131 +++++++++++++
 tb/tb_ram_dump_reader.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the MPU byte-wide RAM port: widths, read/write
// encoding and the dump reader's state encoding.
package sparc_mem_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;

    // ReadWrite encoding shared with the RAM and the preload writer.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EMIT = 3'd3,
        ST_FIN  = 3'd4
    } rdr_state_e;

    // The reader owns the RAM port in REQ, WAIT and EMIT only.
    function automatic logic rdr_owns_port(input rdr_state_e s);
        return (s == ST_REQ) || (s == ST_WAIT) || (s == ST_EMIT);
    endfunction

endpackage

// File: rtl/mem_req_timer.sv
// Counts WAIT cycles of one RAM request and flags a timeout once
// MOC_TIMEOUT cycles have elapsed without MemMOC.
module mem_req_timer #(
    parameter int MOC_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(MOC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MOC_TIMEOUT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    // Timeout fires during the MOC_TIMEOUT-th wait cycle so the FSM leaves
    // WAIT after exactly MOC_TIMEOUT cycles.
    assign expired_o = run_i && (count_q == LAST);

    // Next count: cleared on a new request, advancing while waiting.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (run_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ram_dump_reader.sv
// Reads Count consecutive RAM bytes from BaseAddr via the Enable/ReadWrite/MOC
// handshake and streams each byte on a valid/ready interface.
module ram_dump_reader #(
    parameter int ADDR_W      = sparc_mem_pkg::ADDR_W,
    parameter int DATA_W      = sparc_mem_pkg::DATA_W,
    parameter int MOC_TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [ADDR_W:0]   Count,
    output logic              MemEnable,
    output logic              MemReadWrite,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemDataIn,
    input  logic              MemMOC,
    output logic [DATA_W-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    import sparc_mem_pkg::*;

    rdr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              error_q, error_d;

    logic timer_clr;
    logic timer_run;
    logic timer_expired;

    assign timer_clr = (state_q == ST_REQ);
    assign timer_run = (state_q == ST_WAIT);

    mem_req_timer #(
        .MOC_TIMEOUT (MOC_TIMEOUT)
    ) u_timer (
        .clk       (Clk),
        .rst_n     (Clr),
        .clear_i   (timer_clr),
        .run_i     (timer_run),
        .expired_o (timer_expired)
    );

    // Outputs decode straight from state/registers so Clr drops them at once.
    assign MemEnable    = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign MemReadWrite = MemEnable ? RW_READ : RW_WRITE;
    assign MemAddr      = addr_q;
    assign OutData      = data_q;
    assign OutValid     = (state_q == ST_EMIT);
    assign Busy         = rdr_owns_port(state_q);
    assign Done         = (state_q == ST_FIN);
    assign Error        = error_q;

    // Next-state and datapath updates for the read/emit sequence.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        error_d = error_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    error_d = 1'b0;
                    if (Count != '0) begin
                        addr_d  = BaseAddr;
                        rem_d   = Count;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // MOC wins over a timeout landing on the same cycle.
                if (MemMOC) begin
                    data_d  = MemDataIn;
                    state_d = ST_EMIT;
                end else if (timer_expired) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (OutReady) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == (ADDR_W+1)'(1)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

endmodule

// File: tb/tb_ram_dump_reader.sv
// Bench for ram_dump_reader: RAM model, scoreboard of expected bytes and
// addresses, and a monitor that checks each handshake against it.
module tb_ram_dump_reader;

    localparam int AW  = 9;
    localparam int DW  = 8;
    localparam int TMO = 15;

    logic          Clk;
    logic          Clr;
    logic          Start;
    logic [AW-1:0] BaseAddr;
    logic [AW:0]   Count;
    logic          MemEnable;
    logic          MemReadWrite;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemDataIn;
    logic          MemMOC;
    logic [DW-1:0] OutData;
    logic          OutValid;
    logic          OutReady;
    logic          Busy;
    logic          Done;
    logic          Error;

    ram_dump_reader #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MOC_TIMEOUT (TMO)
    ) dut (
        .Clk          (Clk),
        .Clr          (Clr),
        .Start        (Start),
        .BaseAddr     (BaseAddr),
        .Count        (Count),
        .MemEnable    (MemEnable),
        .MemReadWrite (MemReadWrite),
        .MemAddr      (MemAddr),
        .MemDataIn    (MemDataIn),
        .MemMOC       (MemMOC),
        .OutData      (OutData),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .Busy         (Busy),
        .Done         (Done),
        .Error        (Error)
    );

    logic [DW-1:0] mem [512];
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] addr_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int en_total = 0;
    int en_high = 0;
    int valid_total = 0;
    int done_total = 0;
    int pop_total = 0;
    bit moc_off = 0;
    bit spurious = 0;
    int moc_delay = 1;
    int rdy_mode = 0;
    int stall_left = 0;
    int stall_at = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        forever begin
            @(posedge Clk);
            cyc++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // RAM model: MOC (with data) moc_delay cycles after the request cycle;
    // optional stray MOC pulses whenever a stray one must be ignored.
    initial begin
        int en_cyc;
        en_cyc = 0;
        MemMOC = 1'b0;
        MemDataIn = '0;
        forever begin
            @(negedge Clk);
            if (!MemEnable) begin
                en_cyc = 0;
                MemMOC = spurious && ($urandom_range(0, 2) == 0);
                MemDataIn = 8'($urandom);
            end else begin
                en_cyc++;
                if (!moc_off && en_cyc == moc_delay + 1) begin
                    MemMOC = 1'b1;
                    MemDataIn = mem[MemAddr];
                end else if (en_cyc == 1 && spurious) begin
                    MemMOC = ($urandom_range(0, 1) == 1);
                    MemDataIn = 8'($urandom);
                end else begin
                    MemMOC = 1'b0;
                    MemDataIn = 8'($urandom);
                end
            end
        end
    end

    // Consumer: always ready, random, or a stall of stall_left cycles on
    // the byte whose index equals stall_at.
    initial begin
        OutReady = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            case (rdy_mode)
                0: OutReady = 1'b1;
                1: OutReady = ($urandom_range(0, 1) == 1);
                default: begin
                    if (OutValid && pop_total == stall_at && stall_left > 0) begin
                        OutReady = 1'b0;
                        stall_left--;
                    end else begin
                        OutReady = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: checks request addresses and streamed bytes against the queues.
    initial begin
        logic          en_prev;
        logic          hold;
        logic [DW-1:0] held;
        logic [DW-1:0] e;
        logic [AW-1:0] a;
        en_prev = 1'b0;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge Clk);
            if (!Clr) begin
                en_prev = 1'b0;
                hold = 1'b0;
            end else begin
                if (MemEnable) en_high++;
                if (MemEnable && !en_prev) begin
                    en_total++;
                    chk("mem_rw", 32'(MemReadWrite), 32'd1);
                    if (addr_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL addr_unexpected: request at %0h, none expected", MemAddr);
                    end else begin
                        a = addr_q.pop_front();
                        chk("mem_addr", 32'(MemAddr), 32'(a));
                    end
                end
                en_prev = MemEnable;
                if (OutValid) begin
                    valid_total++;
                    if (hold) chk("out_hold", 32'(OutData), 32'(held));
                    if (OutReady) begin
                        pop_total++;
                        hold = 1'b0;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL out_unexpected: byte %0h, none expected", OutData);
                        end else begin
                            e = exp_q.pop_front();
                            chk("out_data", 32'(OutData), 32'(e));
                        end
                    end else begin
                        hold = 1'b1;
                        held = OutData;
                    end
                end else begin
                    hold = 1'b0;
                end
                if (Done) done_total++;
            end
        end
    end

    task automatic start_xfer(input logic [AW-1:0] base, input logic [AW:0] cnt,
                              input int nbytes, input int naddr);
        logic [AW-1:0] ad;
        for (int i = 0; i < naddr; i++) begin
            ad = base + AW'(i);
            addr_q.push_back(ad);
            if (i < nbytes) exp_q.push_back(mem[ad]);
        end
        @(posedge Clk);
        #1;
        Start = 1'b1;
        BaseAddr = base;
        Count = cnt;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        BaseAddr = AW'($urandom);
        Count = (AW+1)'($urandom);
    endtask

    task automatic wait_done(input int maxc, output int at);
        int k;
        k = 0;
        at = -1;
        while (k < maxc) begin
            @(negedge Clk);
            if (Done === 1'b1) begin
                at = cyc;
                break;
            end
            k++;
        end
        if (k >= maxc) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: no Done within %0d cycles", maxc);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic check_xfer(input string tag, input int d0, input int e0, input int cnt);
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_addr_drain"}, 32'(addr_q.size()), 32'd0);
        chk({tag, "_done_pulses"}, 32'(done_total - d0), 32'd1);
        chk({tag, "_mem_requests"}, 32'(en_total - e0), 32'(cnt));
        chk({tag, "_busy_after"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        int d0, e0, h0, v0, c0, at, k, cnt;
        logic [AW-1:0] base;
        Clr = 1'b0;
        Start = 1'b0;
        BaseAddr = '0;
        Count = '0;
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);

        repeat (3) @(posedge Clk);
        #2;
        chk("reset_outputs", 32'({MemEnable, MemReadWrite, MemAddr, OutData, OutValid, Busy, Done, Error}), 32'd0);
        Clr = 1'b1;
        @(negedge Clk);
        chk("idle_busy", 32'(Busy), 32'd0);

        // 16-byte dump at full rate.
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
        d0 = done_total; e0 = en_total;
        start_xfer(9'h000, 10'd16, 16, 16);
        c0 = cyc;
        wait_done(200, at);
        chk("t1_req_to_fin_cycles", 32'(at - c0), 32'd48);
        check_xfer("t1", d0, e0, 16);

        // Address wrap at the top of RAM.
        mem[9'h1FE] = 8'h11; mem[9'h1FF] = 8'h22; mem[9'h000] = 8'h33; mem[9'h001] = 8'h44;
        d0 = done_total; e0 = en_total;
        start_xfer(9'h1FE, 10'd4, 4, 4);
        wait_done(200, at);
        check_xfer("t2", d0, e0, 4);

        // Consumer stalls 10 cycles on the second byte.
        rdy_mode = 2; stall_left = 10; stall_at = pop_total + 1;
        d0 = done_total; e0 = en_total;
        start_xfer(9'h020, 10'd4, 4, 4);
        wait_done(200, at);
        check_xfer("t3", d0, e0, 4);
        chk("t3_stall_taken", 32'(stall_left), 32'd0);
        rdy_mode = 0;

        // No MOC: timeout, sticky Error, no Done; next Start clears Error.
        moc_off = 1;
        d0 = done_total; e0 = en_total; h0 = en_high;
        start_xfer(9'h030, 10'd3, 0, 1);
        k = 0;
        while (k < 100 && Error !== 1'b1) begin
            @(negedge Clk);
            k++;
        end
        if (k >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL t4_error_timeout: Error not raised within 100 cycles");
        end
        @(posedge Clk);
        #1;
        chk("t4_error", 32'(Error), 32'd1);
        chk("t4_mem_enable", 32'(MemEnable), 32'd0);
        chk("t4_busy", 32'(Busy), 32'd0);
        chk("t4_enable_cycles", 32'(en_high - h0), 32'(TMO + 1));
        chk("t4_addr_drain", 32'(addr_q.size()), 32'd0);
        repeat (5) @(negedge Clk);
        chk("t4_error_sticky", 32'(Error), 32'd1);
        chk("t4_no_done", 32'(done_total - d0), 32'd0);
        moc_off = 0;
        d0 = done_total; e0 = en_total;
        start_xfer(9'h031, 10'd2, 2, 2);
        @(negedge Clk);
        chk("t4_error_cleared", 32'(Error), 32'd0);
        wait_done(200, at);
        check_xfer("t4b", d0, e0, 2);

        // Count = 0: Done next cycle, no RAM access, no output.
        d0 = done_total; e0 = en_total; v0 = valid_total;
        start_xfer(9'h055, 10'd0, 0, 0);
        @(negedge Clk);
        chk("t5_done", 32'(Done), 32'd1);
        repeat (3) @(negedge Clk);
        chk("t5_no_request", 32'(en_total - e0), 32'd0);
        chk("t5_no_valid", 32'(valid_total - v0), 32'd0);
        chk("t5_done_pulses", 32'(done_total - d0), 32'd1);

        // Clr during WAIT of the third byte.
        moc_delay = 4;
        e0 = en_total;
        start_xfer(9'h040, 10'd5, 5, 5);
        k = 0;
        while (k < 100 && (en_total - e0) < 3) begin
            @(negedge Clk);
            k++;
        end
        if (k >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL t6_third_request: not seen within 100 cycles");
        end
        @(posedge Clk);
        #3;
        Clr = 1'b0;
        #1;
        chk("t6_clr_outputs", 32'({MemEnable, MemReadWrite, MemAddr, OutData, OutValid, Busy, Done, Error}), 32'd0);
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge Clk);
        #3;
        Clr = 1'b1;
        @(negedge Clk);
        chk("t6_idle_after_clr", 32'({Busy, MemEnable, OutValid}), 32'd0);
        moc_delay = 1;
        d0 = done_total; e0 = en_total;
        start_xfer(9'h080, 10'd6, 6, 6);
        repeat (4) @(posedge Clk);
        #1;
        Start = 1'b1; BaseAddr = 9'h100; Count = 10'd2;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        wait_done(300, at);
        check_xfer("t6", d0, e0, 6);
        repeat (3) @(negedge Clk);
        chk("t6_stays_idle", 32'(Busy), 32'd0);

        // Random transfers with stray MOCs and random back-pressure.
        spurious = 1;
        rdy_mode = 1;
        for (int t = 0; t < 8; t++) begin
            base = AW'($urandom);
            cnt = $urandom_range(1, 24);
            moc_delay = $urandom_range(1, 4);
            d0 = done_total; e0 = en_total;
            start_xfer(base, (AW+1)'(cnt), cnt, cnt);
            wait_done(cnt * 40 + 50, at);
            check_xfer("rnd", d0, e0, cnt);
        end

        // Full 512-byte dump from a non-zero base.
        moc_delay = 1;
        d0 = done_total; e0 = en_total;
        start_xfer(9'h123, 10'd512, 512, 512);
        wait_done(20000, at);
        check_xfer("full", d0, e0, 512);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
